// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage. Owns the fetch PC, issues requests to instruction
// memory over a req/ack handshake, and buffers returned words in a small
// prefetch queue. The queue head is presented to decode and the hazard unit.
// The head is held while hasHazard is high. A taken branch flushes the queue
// and redirects fetch.
//
// Parameters
//   RESET_PC : first fetch address after reset (word aligned)
//   DEPTH    : prefetch queue entries (2 or 4)
//
// Ports
//   clk           in   clock, all state on posedge
//   rst           in   synchronous reset, active high
//   hasHazard     in   hold the queue head (no pop)
//   branch_taken  in   one-cycle redirect pulse
//   branch_target in   redirect address, bits [1:0] forced to 0
//   imem_req      out  memory request
//   imem_addr     out  request address, stable while imem_req is high
//   imem_ack      in   memory completion (only meaningful while imem_req)
//   imem_rdata    in   returned instruction word, valid with imem_ack
//   IR_IF         out  queue head instruction, 0 (NOP) when empty
//   PC_IF         out  address of IR_IF, 0 when empty
//   valid_IF      out  queue non-empty
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hasHazard,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IR_IF,
   output logic [31:0] PC_IF,
   output logic        valid_IF
);

   localparam int             CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [31:0]               fetch_pc_q, fetch_pc_d;
   // Address of a request abandoned by a redirect; kept on the bus until
   // memory acknowledges it so imem_addr stays stable while imem_req is high.
   logic [31:0]               drop_addr_q, drop_addr_d;
   logic [CW-1:0]             count_q, count_d;
   logic [DEPTH-1:0][31:0]    q_pc_q, q_pc_d;
   logic [DEPTH-1:0][31:0]    q_ir_q, q_ir_d;

   logic        pop;
   logic        push;
   logic [31:0] redirect_pc;
   logic [CW-1:0] wr_idx;

   // Masking keeps every target bit in use while forcing word alignment.
   assign redirect_pc = branch_target & 32'hFFFF_FFFC;

   // Head outputs come straight from registers; only the empty mux sits in
   // front of them, so hasHazard has no path to IR_IF/PC_IF.
   assign valid_IF = (count_q != '0);
   assign IR_IF    = valid_IF ? q_ir_q[0] : 32'h0000_0000;
   assign PC_IF    = valid_IF ? q_pc_q[0] : 32'h0000_0000;

   assign imem_req  = (state_q != S_IDLE);
   assign imem_addr = (state_q == S_DROP) ? drop_addr_q : fetch_pc_q;

   assign pop  = valid_IF && !hasHazard && !branch_taken;
   // A word returned in the redirect cycle belongs to the old path.
   assign push = (state_q == S_REQ) && imem_ack && !branch_taken;

   // Slot for the pushed word: behind whatever survives this cycle's pop.
   assign wr_idx = count_q - CW'(pop);

   // -------------------------------------------------------------------------
   // Queue next-state: shift toward the head on pop, then append on push.
   // -------------------------------------------------------------------------
   always_comb begin
      q_pc_d  = q_pc_q;
      q_ir_d  = q_ir_q;
      count_d = count_q;
      if (branch_taken) begin
         count_d = '0;
      end else begin
         if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               q_pc_d[i] = q_pc_q[i+1];
               q_ir_d[i] = q_ir_q[i+1];
            end
            q_pc_d[DEPTH-1] = 32'h0000_0000;
            q_ir_d[DEPTH-1] = 32'h0000_0000;
         end
         if (push) begin
            q_pc_d[wr_idx] = fetch_pc_q;
            q_ir_d[wr_idx] = imem_rdata;
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // -------------------------------------------------------------------------
   // Fetch FSM next-state
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      drop_addr_d = drop_addr_q;
      unique case (state_q)
         S_IDLE: begin
            if (branch_taken) begin
               fetch_pc_d = redirect_pc;
               state_d    = S_REQ;
            end else if (count_q < DEPTH_C) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (branch_taken) begin
               fetch_pc_d = redirect_pc;
               if (imem_ack) begin
                  state_d = S_REQ;
               end else begin
                  // Request still in flight: wait it out with the old address.
                  drop_addr_d = fetch_pc_q;
                  state_d     = S_DROP;
               end
            end else if (imem_ack) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
               // Only keep requesting when the next word has a guaranteed slot.
               state_d    = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
            end
         end
         S_DROP: begin
            if (branch_taken) begin
               fetch_pc_d = redirect_pc;
            end
            // Once the abandoned request completes there is nothing left in
            // flight, so fetch of the (latest) target can start.
            if (imem_ack) begin
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         fetch_pc_q  <= RESET_PC;
         drop_addr_q <= RESET_PC;
         count_q     <= '0;
         q_pc_q      <= '0;
         q_ir_q      <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         drop_addr_q <= drop_addr_d;
         count_q     <= count_d;
         q_pc_q      <= q_pc_d;
         q_ir_q      <= q_ir_d;
      end
   end

endmodule
